// File: rtl/retire_trace_serializer.sv
// Retirement trace serializer: compacts up to two retirements per cycle into
// a FIFO of sequence-numbered entries that a cosim consumer drains one by one.
module retire_trace_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               retire_valid_i,
  input  logic [63:0]              retire_pc_i,
  input  logic [63:0]              retire_inst_i,
  input  logic [1:0]               retire_rd_valid_i,
  input  logic [9:0]               retire_rd_addr_i,
  input  logic [63:0]              retire_rd_data_i,
  input  logic                     halt_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_seq_o,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_inst_o,
  output logic [31:0]              out_rd_data_o,
  output logic                     out_rd_valid_o,
  output logic [4:0]               out_rd_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     drained_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // entry layout: {seq, pc, inst, rd_valid, rd_addr, rd_data}
  localparam int EW = 32 + 32 + 32 + 1 + 5 + 32;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_seq;
  logic          r_overflow;
  logic          r_halted;

  logic [1:0]    w_v;
  logic [1:0]    w_p;
  logic [CW-1:0] w_free;
  logic          w_fits;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_e0;
  logic [EW-1:0] w_e1;
  logic [EW-1:0] w_first;
  logic [EW-1:0] w_head;

  // Retirements on or after the halt cycle are invisible to the trace.
  assign w_v    = retire_valid_i & {2{~r_halted & ~halt_i}};
  assign w_p    = {1'b0, w_v[0]} + {1'b0, w_v[1]};
  assign w_free = CW'(DEPTH) - r_count;
  assign w_fits = CW'(w_p) <= w_free;
  assign w_push = (w_p != 2'd0) && w_fits;
  assign w_pop  = out_valid_o && out_ready_i;

  // Lane 1 takes the next number only when lane 0 consumed one.
  assign w_e0 = {r_seq, retire_pc_i[31:0], retire_inst_i[31:0],
                 retire_rd_valid_i[0], retire_rd_addr_i[4:0],
                 retire_rd_data_i[31:0]};
  assign w_e1 = {r_seq + {31'd0, w_v[0]},
                 retire_pc_i[63:32], retire_inst_i[63:32],
                 retire_rd_valid_i[1], retire_rd_addr_i[9:5],
                 retire_rd_data_i[63:32]};
  assign w_first = w_v[0] ? w_e0 : w_e1;

  // Entry storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= w_first;
      if (w_p == 2'd2)
        r_mem[r_wptr + AW'(1)] <= w_e1;
    end
  end

  // Pointers, occupancy, sequence counter and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(w_p);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (w_push ? CW'(w_p) : CW'(0))
                         - CW'(w_pop);
      r_seq <= r_seq + {30'd0, w_p};
      if ((w_p != 2'd0) && !w_fits)
        r_overflow <= 1'b1;
      if (halt_i)
        r_halted <= 1'b1;
    end
  end

  assign w_head = r_mem[r_rptr];

  assign out_valid_o    = r_count != '0;
  assign out_seq_o      = out_valid_o ? w_head[133:102] : '0;
  assign out_pc_o       = out_valid_o ? w_head[101:70]  : '0;
  assign out_inst_o     = out_valid_o ? w_head[69:38]   : '0;
  assign out_rd_valid_o = out_valid_o ? w_head[37]      : 1'b0;
  assign out_rd_addr_o  = out_valid_o ? w_head[36:32]   : '0;
  assign out_rd_data_o  = out_valid_o ? w_head[31:0]    : '0;
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign drained_o      = r_halted && (r_count == '0);

endmodule

// File: tb/tb_retire_trace_serializer.sv
// Bench for retire_trace_serializer: directed scenarios checked every cycle
// against a queue-based model, plus literal expectations.
module tb_retire_trace_serializer;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [1:0]  retire_valid_i;
  logic [63:0] retire_pc_i;
  logic [63:0] retire_inst_i;
  logic [1:0]  retire_rd_valid_i;
  logic [9:0]  retire_rd_addr_i;
  logic [63:0] retire_rd_data_i;
  logic        halt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_seq_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic [31:0] out_rd_data_o;
  logic        out_rd_valid_o;
  logic [4:0]  out_rd_addr_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic        drained_o;

  retire_trace_serializer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .retire_valid_i(retire_valid_i),
    .retire_pc_i(retire_pc_i),
    .retire_inst_i(retire_inst_i),
    .retire_rd_valid_i(retire_rd_valid_i),
    .retire_rd_addr_i(retire_rd_addr_i),
    .retire_rd_data_i(retire_rd_data_i),
    .halt_i(halt_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_seq_o(out_seq_o),
    .out_pc_o(out_pc_o),
    .out_inst_o(out_inst_o),
    .out_rd_data_o(out_rd_data_o),
    .out_rd_valid_o(out_rd_valid_o),
    .out_rd_addr_o(out_rd_addr_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .drained_o(drained_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rda;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_seq;
  logic        m_ovf;
  logic        m_halt;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int         sz;
    bit         pop;
    logic [1:0] v;
    int         p;
    ent_t       nw[$];
    logic [31:0] s;
    if (reset) begin
      q.delete();
      m_seq  = 0;
      m_ovf  = 0;
      m_halt = 0;
      return;
    end
    sz  = q.size();
    pop = (sz != 0) && out_ready_i;
    v   = (m_halt || halt_i) ? 2'b00 : retire_valid_i;
    p   = int'(v[0]) + int'(v[1]);
    if (halt_i) m_halt = 1;
    s = m_seq;
    for (int l = 0; l < 2; l++) begin
      if (v[l]) begin
        ent_t e;
        e.seq  = s;
        e.pc   = retire_pc_i[32*l +: 32];
        e.inst = retire_inst_i[32*l +: 32];
        e.rdv  = retire_rd_valid_i[l];
        e.rda  = retire_rd_addr_i[5*l +: 5];
        e.data = retire_rd_data_i[32*l +: 32];
        nw.push_back(e);
        s = s + 1;
      end
    end
    m_seq = m_seq + 32'(p);
    if (pop) void'(q.pop_front());
    if (p > DEPTH - sz) m_ovf = 1;
    else foreach (nw[i]) q.push_back(nw[i]);
  endtask

  task automatic compare();
    int sz;
    sz = q.size();
    chk("count", 32'(count_o), 32'(sz));
    chk("valid", 32'(out_valid_o), 32'(sz != 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drained", 32'(drained_o), 32'(m_halt && sz == 0));
    if (sz != 0) begin
      chk("seq", out_seq_o, q[0].seq);
      chk("pc", out_pc_o, q[0].pc);
      chk("inst", out_inst_o, q[0].inst);
      chk("rdv", 32'(out_rd_valid_o), 32'(q[0].rdv));
      chk("rda", 32'(out_rd_addr_o), 32'(q[0].rda));
      chk("data", out_rd_data_o, q[0].data);
    end else if (reset) begin
      chk("rst_fields", out_seq_o | out_pc_o | out_inst_o | out_rd_data_o
          | 32'(out_rd_addr_o) | 32'(out_rd_valid_o), 32'd0);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic ret(input logic [1:0] v, input logic [31:0] p0,
                     input logic [31:0] p1);
    retire_valid_i    = v;
    retire_pc_i       = {p1, p0};
    retire_inst_i     = {p1 ^ 32'h13, p0 ^ 32'h13};
    retire_rd_valid_i = {p1[2], p0[2]};
    retire_rd_addr_i  = {p1[6:2], p0[6:2]};
    retire_rd_data_i  = {p1 + 32'd1000, p0 + 32'd1000};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ret(2'b00, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_seq = 0; m_ovf = 0; m_halt = 0;
    reset = 1'b1; halt_i = 1'b0; out_ready_i = 1'b0;
    ret(2'b00, 0, 0);
    cyc(); cyc();
    chk("L_rst_count", 32'(count_o), 0);
    chk("L_rst_valid", 32'(out_valid_o), 0);
    reset = 1'b0;

    // single lane-0 retire, consumer ready
    out_ready_i = 1'b1;
    retire_valid_i = 2'b01;
    retire_pc_i = {32'd0, 32'h80};
    retire_inst_i = {32'd0, 32'h0010_0093};
    retire_rd_valid_i = 2'b01;
    retire_rd_addr_i = {5'd0, 5'd1};
    retire_rd_data_i = {32'd0, 32'd1};
    cyc();
    ret(2'b00, 0, 0);
    chk("L18_valid", 32'(out_valid_o), 1);
    chk("L18_seq", out_seq_o, 0);
    chk("L18_pc", out_pc_o, 32'h80);
    chk("L18_inst", out_inst_o, 32'h0010_0093);
    chk("L18_rd", {26'd0, out_rd_valid_o, out_rd_addr_o}, 32'h21);
    chk("L18_data", out_rd_data_o, 1);
    cyc();
    chk("L18_count", 32'(count_o), 0);

    // dual retire, stalled consumer, then drain in order
    do_reset();
    out_ready_i = 1'b0;
    ret(2'b11, 32'h100, 32'h104);
    cyc();
    ret(2'b00, 0, 0);
    chk("L19_count", 32'(count_o), 2);
    chk("L19_pc0", out_pc_o, 32'h100);
    cyc();
    chk("L19_hold", out_pc_o, 32'h100);
    out_ready_i = 1'b1;
    cyc();
    chk("L19_seq1", out_seq_o, 1);
    chk("L19_pc1", out_pc_o, 32'h104);
    cyc();
    chk("L19_empty", 32'(count_o), 0);

    // fill to 7, dual retire dropped, next accepted has seq 9
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ret(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i));
      cyc();
    end
    ret(2'b01, 32'h1100, 0);
    cyc();
    ret(2'b11, 32'h1200, 32'h1204);
    cyc();
    chk("L20_count", 32'(count_o), 7);
    chk("L20_ovf", 32'(overflow_o), 1);
    ret(2'b10, 0, 32'h200);
    cyc();
    ret(2'b00, 0, 0);
    chk("L20_full", 32'(count_o), 8);
    out_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("L20_seq9", out_seq_o, 9);
    chk("L20_pc", out_pc_o, 32'h200);
    cyc();

    // full FIFO, pop and retire same cycle: space is checked before pop
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret(2'b11, 32'h2000 + 32'(8*i), 32'h2004 + 32'(8*i));
      cyc();
    end
    chk("L21_full", 32'(count_o), 8);
    chk("L21_noovf", 32'(overflow_o), 0);
    out_ready_i = 1'b1;
    ret(2'b01, 32'h2100, 0);
    cyc();
    ret(2'b00, 0, 0);
    chk("L21_count", 32'(count_o), 7);
    chk("L21_ovf", 32'(overflow_o), 1);

    // reset mid-operation discards everything
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("L17_count", 32'(count_o), 0);
    chk("L17_ovf", 32'(overflow_o), 0);

    // sequence wrap on lane-1-only retires
    out_ready_i = 1'b0;
    force dut.r_seq = 32'hFFFF_FFFF;
    #1;
    release dut.r_seq;
    m_seq = 32'hFFFF_FFFF;
    ret(2'b10, 0, 32'h300);
    cyc();
    ret(2'b10, 0, 32'h304);
    cyc();
    ret(2'b00, 0, 0);
    chk("L23_seqA", out_seq_o, 32'hFFFF_FFFF);
    out_ready_i = 1'b1;
    cyc();
    chk("L23_seqB", out_seq_o, 32'h0000_0000);
    chk("L23_pc", out_pc_o, 32'h304);
    cyc();

    // halt with dual retire, three buffered entries
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ret(2'b01, 32'h400 + 32'(4*i), 0);
      cyc();
    end
    halt_i = 1'b1;
    ret(2'b11, 32'h500, 32'h504);
    cyc();
    halt_i = 1'b0;
    chk("L22_count", 32'(count_o), 3);
    ret(2'b01, 32'h600, 0);
    cyc();
    ret(2'b00, 0, 0);
    chk("L22_ignored", 32'(count_o), 3);
    chk("L22_notdrained", 32'(drained_o), 0);
    out_ready_i = 1'b1;
    cyc();
    cyc();
    chk("L22_last_pc", out_pc_o, 32'h408);
    chk("L22_still", 32'(drained_o), 0);
    cyc();
    chk("L22_drained", 32'(drained_o), 1);
    chk("L22_empty", 32'(count_o), 0);
    cyc();
    chk("L22_sticky", 32'(drained_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
